// File: rtl/alu_seq.sv
// Multi-cycle RV32I integer ALU with valid/ready handshakes on both sides.
// Single-cycle arithmetic/logic; shifts iterate one bit position per cycle.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [3:0]       i_ALUControlLines,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [WIDTH-1:0] o_Result,
    output logic             o_Zero
);

    localparam int unsigned ShW = $clog2(WIDTH);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b1000;
    localparam logic [3:0] OpSll  = 4'b0001;
    localparam logic [3:0] OpSlt  = 4'b0010;
    localparam logic [3:0] OpSltu = 4'b0011;
    localparam logic [3:0] OpXor  = 4'b0100;
    localparam logic [3:0] OpSrl  = 4'b0101;
    localparam logic [3:0] OpSra  = 4'b1101;
    localparam logic [3:0] OpOr   = 4'b0110;
    localparam logic [3:0] OpAnd  = 4'b0111;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [ShW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] acc_step;
    logic             in_is_shift;
    logic [ShW-1:0]   in_amount;

    assign in_is_shift = (i_ALUControlLines == OpSll) || (i_ALUControlLines == OpSrl) ||
                         (i_ALUControlLines == OpSra);
    assign in_amount   = i_B[ShW-1:0];

    always_comb begin
        alu_out = '0;
        case (i_ALUControlLines)
            OpAdd:   alu_out = i_A + i_B;
            OpSub:   alu_out = i_A - i_B;
            OpSlt:   alu_out = {{(WIDTH-1){1'b0}}, ($signed(i_A) < $signed(i_B))};
            OpSltu:  alu_out = {{(WIDTH-1){1'b0}}, (i_A < i_B)};
            OpXor:   alu_out = i_A ^ i_B;
            OpOr:    alu_out = i_A | i_B;
            OpAnd:   alu_out = i_A & i_B;
            default: alu_out = '0;
        endcase
    end

    // One bit position per SHIFT cycle, direction/fill chosen by the captured op.
    always_comb begin
        acc_step = acc_q;
        case (op_q)
            OpSll:   acc_step = {acc_q[WIDTH-2:0], 1'b0};
            OpSrl:   acc_step = {1'b0, acc_q[WIDTH-1:1]};
            OpSra:   acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: acc_step = acc_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (i_Valid) begin
                    op_d = i_ALUControlLines;
                    if (in_is_shift && (in_amount != '0)) begin
                        acc_d   = i_A;
                        cnt_d   = in_amount;
                        state_d = StShift;
                    end else begin
                        result_d = in_is_shift ? i_A : alu_out;
                        state_d  = StDone;
                    end
                end
            end
            StShift: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == ShW'(1)) begin
                    result_d = acc_step;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (i_Ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign o_Ready  = (state_q == StIdle);
    assign o_Valid  = (state_q == StDone);
    assign o_Result = result_q;
    assign o_Zero   = (result_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq: vector table plus handshake,
// back-to-back and reset sequences.
module tb_alu_seq;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_Valid = 1'b0;
    logic        o_Ready;
    logic [3:0]  i_ALUControlLines = 4'b0000;
    logic [31:0] i_A = '0;
    logic [31:0] i_B = '0;
    logic        o_Valid;
    logic        i_Ready = 1'b0;
    logic [31:0] o_Result;
    logic        o_Zero;

    int n_pass = 0;
    int n_total = 0;

    alu_seq #(.WIDTH(32)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_Valid           (i_Valid),
        .o_Ready           (o_Ready),
        .i_ALUControlLines (i_ALUControlLines),
        .i_A               (i_A),
        .i_B               (i_B),
        .o_Valid           (o_Valid),
        .i_Ready           (i_Ready),
        .o_Result          (o_Result),
        .o_Zero            (o_Zero)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        int          lat;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Issue one request from IDLE, scramble inputs after accept, wait for o_Valid.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        @(negedge i_clk);
        i_ALUControlLines = op;
        i_A = a;
        i_B = b;
        i_Valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_Valid = 1'b0;
        i_A = ~a;
        i_B = b ^ 32'h0000_001f;
        i_ALUControlLines = 4'b0000;
        lat = 1;
        while (!o_Valid && lat < 100) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_done(input string nm);
        i_Ready = 1'b1;
        @(posedge i_clk);
        #1;
        chk({nm, " idle ready"}, {31'd0, o_Ready}, 32'd1);
        chk({nm, " idle valid"}, {31'd0, o_Valid}, 32'd0);
        i_Ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic saw_valid;

        vq.push_back('{"add_wrap",  4'b0000, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b1, 1});
        vq.push_back('{"add",       4'b0000, 32'd7,         32'd8,         32'h0000_000F, 1'b0, 1});
        vq.push_back('{"sub_wrap",  4'b1000, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1});
        vq.push_back('{"slt",       4'b0010, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 1'b0, 1});
        vq.push_back('{"sltu",      4'b0011, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b1, 1});
        vq.push_back('{"xor",       4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1});
        vq.push_back('{"or",        4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1});
        vq.push_back('{"and",       4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1});
        vq.push_back('{"sra4",      4'b1101, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 5});
        vq.push_back('{"srl4",      4'b0101, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 5});
        vq.push_back('{"sll31",     4'b0001, 32'd1,         32'd31,        32'h8000_0000, 1'b0, 32});
        vq.push_back('{"sll_amt0",  4'b0001, 32'h1234_5678, 32'd32,        32'h1234_5678, 1'b0, 1});
        vq.push_back('{"sll_capt",  4'b0001, 32'd3,         32'd2,         32'd12,        1'b0, 3});
        vq.push_back('{"illegal",   4'b1111, 32'h1234_5678, 32'd9,         32'h0000_0000, 1'b1, 1});

        // Reset state
        #12;
        chk("rst ready", {31'd0, o_Ready}, 32'd1);
        chk("rst valid", {31'd0, o_Valid}, 32'd0);
        chk("rst result", o_Result, 32'd0);
        chk("rst zero", {31'd0, o_Zero}, 32'd1);
        @(negedge i_clk);
        i_rst = 1'b0;

        foreach (vq[i]) begin
            chk({vq[i].name, " pre ready"}, {31'd0, o_Ready}, 32'd1);
            issue(vq[i].op, vq[i].a, vq[i].b, lat);
            chk({vq[i].name, " latency"}, lat, vq[i].lat);
            chk({vq[i].name, " result"}, o_Result, vq[i].res);
            chk({vq[i].name, " zero"}, {31'd0, o_Zero}, {31'd0, vq[i].zero});
            chk({vq[i].name, " busy"}, {31'd0, o_Ready}, 32'd0);
            release_done(vq[i].name);
        end

        // Back-pressure with i_Valid pulses ignored during SHIFT and DONE
        @(negedge i_clk);
        i_ALUControlLines = 4'b0101;
        i_A = 32'hF000_0000;
        i_B = 32'd3;
        i_Valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_ALUControlLines = 4'b0000;
        i_A = 32'd1;
        i_B = 32'd1;
        lat = 1;
        while (!o_Valid && lat < 100) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        chk("bp latency", lat, 4);
        chk("bp result", o_Result, 32'h1E00_0000);
        for (int k = 0; k < 10; k++) begin
            @(posedge i_clk);
            #1;
            if (o_Valid !== 1'b1 || o_Result !== 32'h1E00_0000 || o_Ready !== 1'b0) begin
                chk("bp hold", {o_Valid, o_Ready, o_Result[29:0]}, {2'b10, 30'h1E00_0000});
            end
        end
        chk("bp hold result", o_Result, 32'h1E00_0000);
        chk("bp hold valid", {31'd0, o_Valid}, 32'd1);
        i_Valid = 1'b0;
        release_done("bp");

        // Back-to-back XOR then AND, one accept every 2 cycles
        @(negedge i_clk);
        i_Ready = 1'b1;
        i_ALUControlLines = 4'b0100;
        i_A = 32'h0000_FFFF;
        i_B = 32'h00FF_00FF;
        i_Valid = 1'b1;
        @(posedge i_clk);
        #1;
        chk("b2b xor valid", {31'd0, o_Valid}, 32'd1);
        chk("b2b xor result", o_Result, 32'h00FF_FF00);
        i_ALUControlLines = 4'b0111;
        @(posedge i_clk);
        #1;
        chk("b2b gap ready", {31'd0, o_Ready}, 32'd1);
        @(posedge i_clk);
        #1;
        i_Valid = 1'b0;
        chk("b2b and valid", {31'd0, o_Valid}, 32'd1);
        chk("b2b and result", o_Result, 32'h0000_00FF);
        @(posedge i_clk);
        #1;
        i_Ready = 1'b0;
        chk("b2b end ready", {31'd0, o_Ready}, 32'd1);

        // Reset mid-SHIFT: amount 20, seven cycles into the shift
        @(negedge i_clk);
        i_ALUControlLines = 4'b0001;
        i_A = 32'd1;
        i_B = 32'd20;
        i_Valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_Valid = 1'b0;
        repeat (7) @(posedge i_clk);
        #1;
        chk("mid shift valid", {31'd0, o_Valid}, 32'd0);
        i_rst = 1'b1;
        #1;
        chk("rst mid valid", {31'd0, o_Valid}, 32'd0);
        chk("rst mid ready", {31'd0, o_Ready}, 32'd1);
        chk("rst mid result", o_Result, 32'd0);
        chk("rst mid zero", {31'd0, o_Zero}, 32'd1);
        @(negedge i_clk);
        i_rst = 1'b0;
        saw_valid = 1'b0;
        repeat (30) begin
            @(negedge i_clk);
            if (o_Valid) saw_valid = 1'b1;
        end
        chk("no valid after rst", {31'd0, saw_valid}, 32'd0);
        chk("post rst ready", {31'd0, o_Ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle integer ALU for the SOIN-RV datapath. It consumes the 4-bit ALU control lines produced by the ALU control decoder and executes the RV32I integer operation on two operands. Add, subtract, compare and logic operations finish in one cycle. Shifts run iteratively, one bit position per cycle. Operands enter and results leave through valid/ready handshakes, so the block can sit between the register-read stage and write-back without a combinational barrel shifter.

## Interface
- WIDTH, 32, operand and result width; must be a power of two, at least 8.
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_Valid  in  1  request valid.
- o_Ready  out  1  block can accept a request (high only in IDLE).
- i_ALUControlLines  in  4  operation code.
- i_A  in  WIDTH  operand A.
- i_B  in  WIDTH  operand B; for shifts, the shift amount is i_B[log2(WIDTH)-1:0].
- o_Valid  out  1  result valid.
- i_Ready  in  1  downstream accepts the result.
- o_Result  out  WIDTH  registered result.
- o_Zero  out  1  high when o_Result == 0 (derived from the register).

## Operation
- Operation codes:
  - 0000 ADD
  - 1000 SUB
  - 0001 SLL
  - 0010 SLT (signed)
  - 0011 SLTU
  - 0100 XOR
  - 0101 SRL
  - 1101 SRA
  - 0110 OR
  - 0111 AND
- Any other code completes in one cycle with o_Result = 0.
- States and transitions:
  - IDLE: o_Ready=1. When i_Valid=1, capture i_A, i_B and the code.
  - From IDLE, a non-shift op goes to DONE with the result registered.
  - From IDLE, a shift op with amount 0 goes to DONE with o_Result = A.
  - From IDLE, a shift op with amount > 0 loads an accumulator with A and a counter with the amount, then goes to SHIFT.
  - SHIFT: each cycle, shift the accumulator by 1 and decrement the counter. SLL fills with 0, SRL fills with 0, SRA replicates the MSB. On the cycle the counter reaches 0, go to DONE with the final value in o_Result.
  - DONE: o_Valid=1. When i_Ready=1, go to IDLE; o_Valid drops the next cycle.
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^WIDTH; there is no overflow output.
  - SLT and SLTU return the comparison in bit 0, zero-extended.
- Inputs are sampled only on the accept cycle. Later changes to i_A, i_B or i_ALUControlLines have no effect.
- i_Valid while o_Ready=0 is ignored, with no queueing.
- o_Result holds its last value outside DONE until the next completion overwrites it.

## Timing
- Reset values, applied asynchronously: state IDLE, o_Ready=1, o_Valid=0, o_Result=0, o_Zero=1, counter 0.
- Latency from the accept edge to o_Valid:
  - Non-shift ops and shift amount 0: 1 cycle.
  - Shift amount n > 0: 1 + n cycles.
  - Maximum: WIDTH cycles (amount WIDTH-1).
- Throughput: at most one request every 2 cycles (accept cycle plus DONE cycle). o_Ready is low during DONE, even when i_Ready=1.
- Back-pressure: with i_Ready=0 in DONE, o_Valid, o_Result and o_Zero stay stable indefinitely.
- Reset asserted in any state, including mid-SHIFT or DONE, returns to the reset values immediately. The pending result is discarded and no o_Valid is emitted after reset releases.
- o_Ready is a function of state only and has no combinational path from i_Valid or i_Ready.

## Test plan
- ADD and SUB wrap:
  - ADD A=0xFFFFFFFF, B=1 -> o_Valid 1 cycle after accept, o_Result=0, o_Zero=1.
  - SUB A=0, B=1 -> o_Result=0xFFFFFFFF.
- Compares:
  - SLT A=0xFFFFFFFF (-1), B=1 -> o_Result=1.
  - SLTU with the same operands -> o_Result=0.
- Shifts:
  - SRA A=0x80000000, B=4 -> o_Valid exactly 5 cycles after accept, o_Result=0xF8000000.
  - SRL with the same operands -> 0x08000000.
  - SLL A=1, B=31 -> o_Result=0x80000000 after 32 cycles.
  - B=32 (amount bits 0) -> 1 cycle, o_Result=A.
- Handshake:
  - Hold i_Ready=0 for 10 cycles in DONE -> o_Valid and o_Result stable, o_Ready=0.
  - i_Valid pulses during SHIFT and DONE are ignored.
  - After i_Ready=1 -> IDLE next cycle.
  - Back-to-back XOR and AND requests -> both results correct, one every 2 cycles.
- Operand capture: change i_A and i_B after the accept of SLL A=3, B=2 -> o_Result=12.
- Reset:
  - Assert i_rst mid-SHIFT (amount 20, cycle 7) -> o_Valid=0, o_Ready=1, o_Result=0 immediately; no o_Valid after release.
  - Illegal code 1111 -> o_Result=0, o_Zero=1, 1-cycle latency.
